apb_bus_arbiter: RTL and testbench



---
 rtl/apb_bus_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_apb_bus_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_bus_arbiter.sv
// ============================================================================
// apb_bus_arbiter
// ----------------------------------------------------------------------------
// Shares one APB completer between two on-chip requesters. A round-robin
// arbiter picks a requester in IDLE, the master then runs the APB SETUP and
// ACCESS phases, waits for pready (or gives up after TIMEOUT_CYC ACCESS
// cycles) and returns a one-cycle done pulse, plus err on a timeout, to the
// granted requester. Every output comes straight from a flop.
//
// Requester handshake: rN_req is raised with rN_addr/rN_wdata/rN_write
// stable and stays high until rN_done pulses. done (and err on a timeout)
// is high for exactly the DONE cycle. The requester must drop req before
// the IDLE cycle that follows; a req still high there is a new transfer.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   rN_req/addr/wdata/write  requester N transfer request and fields
//   rN_done, rN_err       one-cycle completion / timeout pulses
//   rdata                 read data, updated on done, held until next done
//   busy, gnt             transfer in flight, owning requester index
//   paddr/pwdata/pwrite/psel/penable  APB master outputs
//   prdata, pready        APB completer response
// ============================================================================
module apb_bus_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_req,
    input  logic              r1_req,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    input  logic [DATA_W-1:0] r1_wdata,
    input  logic              r0_write,
    input  logic              r1_write,
    output logic              r0_done,
    output logic              r1_done,
    output logic              r0_err,
    output logic              r1_err,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              gnt,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    output logic              pwrite,
    output logic              psel,
    output logic              penable,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_gnt_q, last_gnt_d;
    logic              gnt_q, gnt_d;
    logic              busy_q, busy_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              pwrite_q, pwrite_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              r0_done_q, r0_done_d;
    logic              r1_done_q, r1_done_d;
    logic              r0_err_q, r0_err_d;
    logic              r1_err_q, r1_err_d;
    logic              pick;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_gnt_d = last_gnt_q;
        gnt_d      = gnt_q;
        busy_d     = busy_q;
        psel_d     = psel_q;
        penable_d  = penable_q;
        paddr_d    = paddr_q;
        pwdata_d   = pwdata_q;
        pwrite_d   = pwrite_q;
        rdata_d    = rdata_q;
        r0_done_d  = 1'b0;
        r1_done_d  = 1'b0;
        r0_err_d   = 1'b0;
        r1_err_d   = 1'b0;
        // Under contention the requester that did not go last wins;
        // otherwise the single active requester is taken.
        pick       = (r0_req && r1_req) ? !last_gnt_q : r1_req;

        case (state_q)
            S_IDLE: begin
                if (r0_req || r1_req) begin
                    gnt_d      = pick;
                    last_gnt_d = pick;
                    paddr_d    = pick ? r1_addr  : r0_addr;
                    pwdata_d   = pick ? r1_wdata : r0_wdata;
                    pwrite_d   = pick ? r1_write : r0_write;
                    psel_d     = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = S_SETUP;
                end
            end
            S_SETUP: begin
                penable_d = 1'b1;
                cnt_d     = CNT_W'(1);
                state_d   = S_ACCESS;
            end
            S_ACCESS: begin
                if (pready) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    if (!pwrite_q) begin
                        rdata_d = prdata;
                    end
                    r0_done_d = !gnt_q;
                    r1_done_d = gnt_q;
                    state_d   = S_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC)) begin
                    // Silent completer: abort without re-issuing the access.
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    rdata_d   = '0;
                    r0_done_d = !gnt_q;
                    r1_done_d = gnt_q;
                    r0_err_d  = !gnt_q;
                    r1_err_d  = gnt_q;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            last_gnt_q <= 1'b1;
            gnt_q      <= 1'b0;
            busy_q     <= 1'b0;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            paddr_q    <= '0;
            pwdata_q   <= '0;
            pwrite_q   <= 1'b0;
            rdata_q    <= '0;
            r0_done_q  <= 1'b0;
            r1_done_q  <= 1'b0;
            r0_err_q   <= 1'b0;
            r1_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_gnt_q <= last_gnt_d;
            gnt_q      <= gnt_d;
            busy_q     <= busy_d;
            psel_q     <= psel_d;
            penable_q  <= penable_d;
            paddr_q    <= paddr_d;
            pwdata_q   <= pwdata_d;
            pwrite_q   <= pwrite_d;
            rdata_q    <= rdata_d;
            r0_done_q  <= r0_done_d;
            r1_done_q  <= r1_done_d;
            r0_err_q   <= r0_err_d;
            r1_err_q   <= r1_err_d;
        end
    end

    assign r0_done = r0_done_q;
    assign r1_done = r1_done_q;
    assign r0_err  = r0_err_q;
    assign r1_err  = r1_err_q;
    assign rdata   = rdata_q;
    assign busy    = busy_q;
    assign gnt     = gnt_q;
    assign paddr   = paddr_q;
    assign pwdata  = pwdata_q;
    assign pwrite  = pwrite_q;
    assign psel    = psel_q;
    assign penable = penable_q;

endmodule

// File: tb/tb_apb_bus_arbiter.sv
// ============================================================================
// tb_apb_bus_arbiter
// Drives two requesters against a small APB completer model. Expected
// completions {requester, err, rdata} are predicted when stimulus is issued
// and checked by an independent monitor on every done pulse.
// ============================================================================
module tb_apb_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          write;
    } txn_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          r0_req = 0, r1_req = 0;
    logic [AW-1:0] r0_addr = '0, r1_addr = '0;
    logic [DW-1:0] r0_wdata = '0, r1_wdata = '0;
    logic          r0_write = 0, r1_write = 0;
    logic          r0_done, r1_done, r0_err, r1_err;
    logic [DW-1:0] rdata;
    logic          busy, gnt;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic          pwrite, psel, penable;
    logic [DW-1:0] prdata = '0;
    logic          pready;

    apb_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r1_req(r1_req),
        .r0_addr(r0_addr), .r1_addr(r1_addr),
        .r0_wdata(r0_wdata), .r1_wdata(r1_wdata),
        .r0_write(r0_write), .r1_write(r1_write),
        .r0_done(r0_done), .r1_done(r1_done),
        .r0_err(r0_err), .r1_err(r1_err),
        .rdata(rdata), .busy(busy), .gnt(gnt),
        .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
        .psel(psel), .penable(penable),
        .prdata(prdata), .pready(pready)
    );

    // ---------------- APB completer model ----------------
    logic [DW-1:0] comp_mem [16] = '{default: '0};
    logic          pready_q = 1'b0;
    int            wcnt = 0;
    int            wait_cyc = 0;
    logic          stuck = 1'b0;
    logic          noise = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            pready_q <= 1'b0;
            wcnt     <= 0;
        end else if (stuck) begin
            pready_q <= 1'b0;
        end else if (psel && penable && !pready_q) begin
            if (wcnt >= wait_cyc) begin
                pready_q <= 1'b1;
                wcnt     <= 0;
                if (pwrite) comp_mem[paddr[5:2]] <= pwdata;
                prdata <= comp_mem[paddr[5:2]];
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            pready_q <= 1'b0;
            wcnt     <= 0;
        end
    end

    // noise drives pready high whenever the bus is not in an ACCESS phase
    assign pready = pready_q | (noise & !(psel & penable));

    // ---------------- scoreboard / reference model ----------------
    logic [DW+1:0] exp_q[$];
    logic [DW-1:0] ref_mem [16] = '{default: '0};
    logic [DW-1:0] m_rdata = '0;
    logic          m_last  = 1'b1;
    int            n_cmp = 0;
    int            n_bad = 0;
    txn_t          q0[$], q1[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic note_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Predict one completion: timeout gives err with rdata 0, a write leaves
    // rdata unchanged, a read returns the stored word.
    task automatic model_issue(input bit who, input txn_t t);
        logic [DW-1:0] rd;
        bit            er;
        int            idx;
        idx = int'(t.addr[5:2]);
        if (stuck) begin
            er = 1'b1;
            rd = '0;
        end else begin
            er = 1'b0;
            if (t.write) begin
                ref_mem[idx] = t.wdata;
                rd = m_rdata;
            end else begin
                rd = ref_mem[idx];
            end
        end
        m_rdata = rd;
        m_last  = who;
        exp_q.push_back({who, er, rd});
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [DW+1:0] e;
        if (!rst && (r0_done || r1_done)) begin
            check("done_overlap", 64'(r0_done & r1_done), 64'(0));
            if (exp_q.size() == 0) begin
                note_fail("unexpected_done");
            end else begin
                e = exp_q.pop_front();
                check("done_who", 64'(r1_done), 64'(e[DW+1]));
                check("err", 64'(r1_done ? r1_err : r0_err), 64'(e[DW]));
                check("rdata", 64'(rdata), 64'(e[DW-1:0]));
                check("gnt", 64'(gnt), 64'(e[DW+1]));
                check("busy_in_done", 64'(busy), 64'(1));
            end
        end
        if (!rst && ((r0_err && !r0_done) || (r1_err && !r1_done)))
            note_fail("err_without_done");
    end

    // ---------------- driver tasks ----------------
    task automatic set_req(input bit who, input logic req, input txn_t t);
        if (who) begin
            r1_req = req; r1_addr = t.addr; r1_wdata = t.wdata; r1_write = t.write;
        end else begin
            r0_req = req; r0_addr = t.addr; r0_wdata = t.wdata; r0_write = t.write;
        end
    endtask

    // Serves one requester's queue: holds req until done, then presents the
    // next transfer in the same cycle (or drops req).
    task automatic drive_req(input bit who);
        txn_t t;
        bit   got;
        while ((who ? q1.size() : q0.size()) != 0) begin
            t = who ? q1.pop_front() : q0.pop_front();
            set_req(who, 1'b1, t);
            got = 1'b0;
            for (int c = 0; c < 300 && !got; c++) begin
                @(negedge clk);
                if (who ? r1_done : r0_done) got = 1'b1;
            end
            if (!got) note_fail("done_timeout");
            set_req(who, 1'b0, t);
        end
    endtask

    task automatic run_batch(input int n0, input int n1, input int wc, input bit nz, input bit stk);
        txn_t t;
        int   i0, i1;
        wait_cyc = wc;
        noise    = nz;
        stuck    = stk;
        for (int i = 0; i < n0 + n1; i++) begin
            t.addr  = AW'($urandom_range(0, 15)) << 2;
            t.wdata = $urandom;
            t.write = 1'($urandom_range(0, 1));
            if (i < n0) q0.push_back(t); else q1.push_back(t);
        end
        i0 = 0;
        i1 = 0;
        while (i0 < n0 || i1 < n1) begin
            if (i0 < n0 && i1 < n1) begin
                if (m_last) begin model_issue(1'b0, q0[i0]); i0++; end
                else        begin model_issue(1'b1, q1[i1]); i1++; end
            end else if (i0 < n0) begin
                model_issue(1'b0, q0[i0]); i0++;
            end else begin
                model_issue(1'b1, q1[i1]); i1++;
            end
        end
        @(negedge clk);
        fork
            drive_req(1'b0);
            drive_req(1'b1);
        join
        repeat (2) @(negedge clk);
        stuck = 1'b0;
        noise = 1'b0;
    endtask

    // Single transfer with phase timing checks; cycle 1 follows the edge
    // that samples req.
    task automatic timed_xfer(input bit who, input bit wr, input logic [AW-1:0] a,
                              input logic [DW-1:0] wd, input int exp_done);
        txn_t t;
        int   done_cyc;
        t.addr  = a;
        t.wdata = wd;
        t.write = wr;
        model_issue(who, t);
        @(negedge clk);
        set_req(who, 1'b1, t);
        done_cyc = 0;
        for (int c = 1; c <= 60 && done_cyc == 0; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 1) begin
                check("setup_psel", 64'(psel), 64'(1));
                check("setup_penable", 64'(penable), 64'(0));
            end
            if (c == 2) check("access_penable", 64'(penable), 64'(1));
            if (who ? r1_done : r0_done) done_cyc = c;
        end
        set_req(who, 1'b0, t);
        check("done_cycle", 64'(done_cyc), 64'(exp_done));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        txn_t t;
        repeat (3) @(negedge clk);
        check("rst_psel", 64'(psel), 64'(0));
        check("rst_penable", 64'(penable), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_gnt", 64'(gnt), 64'(0));
        check("rst_rdata", 64'(rdata), 64'(0));
        check("rst_paddr", 64'(paddr), 64'(0));
        check("rst_done", 64'({r0_done, r1_done, r0_err, r1_err}), 64'(0));
        rst = 1'b0;

        timed_xfer(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4);
        check("completer_word", 64'(comp_mem[4]), 64'h0000_0000_DEAD_BEEF);
        timed_xfer(1'b1, 1'b0, 32'h10, 32'h0, 4);

        // contention: r0, r1, r0, r1
        run_batch(2, 2, 0, 1'b0, 1'b0);

        // silent completer
        stuck = 1'b1;
        timed_xfer(1'b0, 1'b0, 32'h10, 32'h0, 2 + TO);
        stuck = 1'b0;
        timed_xfer(1'b0, 1'b0, 32'h10, 32'h0, 4);

        // pready forced high outside ACCESS, two wait states
        noise    = 1'b1;
        wait_cyc = 2;
        timed_xfer(1'b1, 1'b1, 32'h20, 32'h1234_5678, 6);
        timed_xfer(1'b0, 1'b0, 32'h20, 32'h0, 6);
        noise    = 1'b0;
        wait_cyc = 0;

        // reset in the first ACCESS cycle
        wait_cyc = 5;
        t.addr   = 32'h8;
        t.wdata  = 32'h0;
        t.write  = 1'b0;
        @(negedge clk);
        set_req(1'b0, 1'b1, t);
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        check("midrst_psel", 64'(psel), 64'(0));
        check("midrst_penable", 64'(penable), 64'(0));
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_rdata", 64'(rdata), 64'(0));
        set_req(1'b0, 1'b0, t);
        rst      = 1'b0;
        m_last   = 1'b1;
        m_rdata  = '0;
        wait_cyc = 0;
        repeat (4) @(negedge clk);
        timed_xfer(1'b1, 1'b0, 32'h20, 32'h0, 4);

        // randomized batches
        for (int b = 0; b < 20; b++) begin
            int n0, n1;
            n0 = $urandom_range(0, 3);
            n1 = $urandom_range(0, 3);
            if (n0 == 0 && n1 == 0) n0 = 1;
            run_batch(n0, n1, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 7) == 0));
        end

        repeat (3) @(negedge clk);
        check("exp_q_drained", 64'(exp_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
